// File: rtl/usr_pkg.sv
// Shared op-codes, USR mode selects and controller state encoding for the
// universal shift register sequencer.
package usr_pkg;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;

    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_SHL  = 2'b01;
    localparam logic [1:0] S_SHR  = 2'b10;
    localparam logic [1:0] S_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_SRA;
    endfunction

endpackage

// File: rtl/usr_core.sv
// Universal shift register: hold, shift left, shift right or parallel load
// selected by s each cycle. q_nxt_c exposes the value Q takes on the next edge.
module usr_core
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       s,
    input  logic             sinr,
    input  logic             sinl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_nxt_c
);

    always_comb begin
        q_nxt_c = q;
        case (s)
            S_HOLD:  q_nxt_c = q;
            S_SHL:   q_nxt_c = {q[WIDTH-2:0], sinl};
            S_SHR:   q_nxt_c = {sinr, q[WIDTH-1:1]};
            default: q_nxt_c = d;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else        q <= q_nxt_c;
    end

endmodule

// File: rtl/usr_shift_ctrl.sv
// Command sequencer for a universal shift register: load, N single-bit shifts,
// then a valid/ready response. Define USR_CTRL_FASTAMT_EN to shorten
// over-range amounts (WIDTH must then be a power of two).
module usr_shift_ctrl
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [1:0]       s,
    output logic             sinr,
    output logic             sinl,
    output logic             busy
);

    state_t             state_q;
    logic [2:0]         op_q;
    logic [CNT_W-1:0]   amt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   data_q;
    logic               err_q;
    logic [WIDTH-1:0]   q_nxt_c;
    logic [CNT_W-1:0]   amt_eff_c;
    logic [1:0]         sh_s_c;
    logic               sh_sinl_c;
    logic               sh_sinr_c;

    usr_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .s       (s),
        .sinr    (sinr),
        .sinl    (sinl),
        .d       (data_q),
        .q       (rsp_data),
        .q_nxt_c (q_nxt_c)
    );

    // Effective shift count; the fast variant trims amounts that cannot change the result further.
    always_comb begin
        amt_eff_c = amt_q;
`ifdef USR_CTRL_FASTAMT_EN
        if (op_q == OP_ROL || op_q == OP_ROR)
            amt_eff_c = amt_q & CNT_W'(WIDTH - 1);
        else if (32'(amt_q) > 32'(WIDTH))
            amt_eff_c = CNT_W'(WIDTH);
`endif
    end

    // Mode and serial-in for the next shift cycle, taken from the value Q holds during that cycle.
    always_comb begin
        sh_s_c    = S_SHR;
        sh_sinl_c = 1'b0;
        sh_sinr_c = 1'b0;
        case (op_q)
            OP_SLL: sh_s_c = S_SHL;
            OP_ROL: begin
                sh_s_c    = S_SHL;
                sh_sinl_c = q_nxt_c[WIDTH-1];
            end
            OP_ROR: sh_sinr_c = q_nxt_c[0];
            OP_SRA: sh_sinr_c = q_nxt_c[WIDTH-1];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            amt_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            s         <= S_HOLD;
            sinr      <= 1'b0;
            sinl      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        amt_q     <= cmd_amt;
                        data_q    <= cmd_data;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= ST_LOAD;
                        // An illegal op spends its decode cycle here with s held, so Q is untouched.
                        err_q     <= !op_legal(cmd_op);
                        s         <= op_legal(cmd_op) ? S_LOAD : S_HOLD;
                    end
                end
                ST_LOAD: begin
                    cnt_q <= amt_eff_c;
                    if (err_q || op_q == OP_LOAD || amt_eff_c == '0) begin
                        state_q   <= ST_RESP;
                        s         <= S_HOLD;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                    end else begin
                        state_q <= ST_SHIFT;
                        s       <= sh_s_c;
                        sinl    <= sh_sinl_c;
                        sinr    <= sh_sinr_c;
                    end
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q   <= ST_RESP;
                        s         <= S_HOLD;
                        sinl      <= 1'b0;
                        sinr      <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        s    <= sh_s_c;
                        sinl <= sh_sinl_c;
                        sinr <= sh_sinr_c;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Bench for usr_shift_ctrl (WIDTH=4): directed table, handshake sequences,
// random commands against an arithmetic reference, and mid-shift reset.
module tb_usr_shift_ctrl;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_amt;
    logic [W-1:0]  cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;
    logic [1:0]    s;
    logic          sinr;
    logic          sinl;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] q_model = '0;

    usr_shift_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .s         (s),
        .sinr      (sinr),
        .sinl      (sinl),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from the op definitions, using plain arithmetic.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [2:0] amt,
                                           input logic [W-1:0] d, input logic [W-1:0] prev);
        logic [2*W-1:0] dd;
        logic signed [W-1:0] sd;
        int k;
        dd = {d, d};
        sd = d;
        k  = int'(amt) % W;
        case (op)
            3'd0: return d;
            3'd1: return (amt >= W) ? '0 : W'(d << amt);
            3'd2: return (amt >= W) ? '0 : W'(d >> amt);
            3'd3: begin dd = dd << k; return dd[2*W-1:W]; end
            3'd4: begin dd = dd >> k; return dd[W-1:0]; end
            3'd5: return (amt >= W) ? {W{d[W-1]}} : W'(sd >>> amt);
            default: return prev;
        endcase
    endfunction

    function automatic int eff_amt(input logic [2:0] op, input logic [2:0] amt);
`ifdef USR_CTRL_FASTAMT_EN
        if (op == 3'd3 || op == 3'd4) return int'(amt) % W;
        if (op == 3'd1 || op == 3'd2 || op == 3'd5) return (amt > W) ? W : int'(amt);
`endif
        return int'(amt);
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [2:0] amt);
        if (op > 3'd5 || op == 3'd0) return 1;
        return eff_amt(op, amt) + 1;
    endfunction

    // Issue one command, follow it to its response, then release it after bp stalled cycles.
    task automatic do_cmd(input logic [2:0] op, input logic [2:0] amt, input logic [W-1:0] data,
                          input logic [W-1:0] exp_data, input logic exp_err, input int exp_lat,
                          input int bp);
        int guard, edges, n_ld, n_sh, bad;
        logic legal;
        logic [1:0] dir;
        legal = (op <= 3'd5);
        dir   = (op == 3'd1 || op == 3'd3) ? 2'b01 : 2'b10;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_idle", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        edges = 0; n_ld = 0; n_sh = 0; bad = 0;
        while (!rsp_valid && edges < 40) begin
            if (s == 2'b11) n_ld++;
            else if (s != 2'b00) begin
                n_sh++;
                if (s != dir) bad++;
                if (s == 2'b01 && sinr) bad++;
                if (s == 2'b10 && sinl) bad++;
            end
            if (cmd_ready) bad++;
            @(negedge clk);
            edges++;
        end
        check("rsp_latency", edges, exp_lat);
        check("rsp_valid", int'(rsp_valid), 1);
        check("rsp_data", int'(rsp_data), int'(exp_data));
        check("rsp_err", int'(rsp_err), int'(exp_err));
        check("load_cycles", n_ld, legal ? 1 : 0);
        check("shift_cycles", n_sh, legal ? exp_lat - 1 : 0);
        check("shift_mode_sin", bad, 0);
        check("resp_s_hold", int'(s), 0);
        for (int i = 0; i < bp; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'd0;
            cmd_data  = ~exp_data;
            @(negedge clk);
            check("bp_rsp_valid", int'(rsp_valid), 1);
            check("bp_rsp_data", int'(rsp_data), int'(exp_data));
            check("bp_cmd_ready", int'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rel_rsp_valid", int'(rsp_valid), 0);
        check("rel_busy", int'(busy), 0);
        q_model = exp_data;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [2:0]   amt;
        logic [W-1:0] data;
        logic [W-1:0] exp_data;
        logic         exp_err;
        int           lat_slow;
        int           lat_fast;
        int           bp;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{3'd5, 3'd2, 4'b1000, 4'b1110, 1'b0, 3, 3, 0};
        tbl[1]  = '{3'd2, 3'd7, 4'b1000, 4'b0000, 1'b0, 8, 5, 1};
        tbl[2]  = '{3'd3, 3'd5, 4'b0011, 4'b0110, 1'b0, 6, 2, 0};
        tbl[3]  = '{3'd1, 3'd2, 4'b1011, 4'b1100, 1'b0, 3, 3, 3};
        tbl[4]  = '{3'd4, 3'd1, 4'b1001, 4'b1100, 1'b0, 2, 2, 0};
        tbl[5]  = '{3'd6, 3'd0, 4'b1111, 4'b1100, 1'b1, 1, 1, 1};
        tbl[6]  = '{3'd0, 3'd3, 4'b0101, 4'b0101, 1'b0, 1, 1, 0};
        tbl[7]  = '{3'd5, 3'd6, 4'b1010, 4'b1111, 1'b0, 7, 5, 0};
        tbl[8]  = '{3'd4, 3'd4, 4'b0001, 4'b0001, 1'b0, 5, 1, 2};
        tbl[9]  = '{3'd7, 3'd2, 4'b0000, 4'b0001, 1'b1, 1, 1, 0};
        tbl[10] = '{3'd3, 3'd0, 4'b1001, 4'b1001, 1'b0, 1, 1, 0};

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_amt   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_s", int'(s), 0);
        check("rst_q", int'(rsp_data), 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", int'(cmd_ready), 1);

        foreach (tbl[i]) begin
`ifdef USR_CTRL_FASTAMT_EN
            do_cmd(tbl[i].op, tbl[i].amt, tbl[i].data, tbl[i].exp_data, tbl[i].exp_err,
                   tbl[i].lat_fast, tbl[i].bp);
`else
            do_cmd(tbl[i].op, tbl[i].amt, tbl[i].data, tbl[i].exp_data, tbl[i].exp_err,
                   tbl[i].lat_slow, tbl[i].bp);
`endif
        end

        // A command held across the response handshake is taken on the following edge.
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_amt = 3'd0; cmd_data = 4'b0101;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("hs_rsp_valid", int'(rsp_valid), 1);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 4'b1010;
        @(negedge clk);
        check("hs_not_taken", int'(rsp_data), 5);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hs_release_valid", int'(rsp_valid), 0);
        check("hs_release_ready", int'(cmd_ready), 1);
        check("hs_release_busy", int'(busy), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hs_accept_busy", int'(busy), 1);
        check("hs_accept_ready", int'(cmd_ready), 0);
        @(negedge clk);
        check("hs_second_valid", int'(rsp_valid), 1);
        check("hs_second_data", int'(rsp_data), 10);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        q_model = 4'b1010;

        for (int n = 0; n < 40; n++) begin
            logic [2:0] op, amt;
            logic [W-1:0] d, e;
            op  = 3'($urandom_range(0, 7));
            amt = 3'($urandom_range(0, 7));
            d   = 4'($urandom_range(0, 15));
            e   = model(op, amt, d, q_model);
            do_cmd(op, amt, d, e, op > 3'd5, model_lat(op, amt), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a long shift discards the command and clears Q.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 3'd7; cmd_data = 4'b1000;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_shifting", int'(s), 2);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_rsp_valid", int'(rsp_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_q", int'(rsp_data), 0);
        check("mid_rst_s", int'(s), 0);
        check("mid_rst_sin", int'({sinr, sinl}), 0);
        check("mid_rst_cmd_ready", int'(cmd_ready), 0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", int'(cmd_ready), 1);
        q_model = '0;
        do_cmd(3'd6, 3'd1, 4'b1111, q_model, 1'b1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usr_shift_ctrl.md
Name: usr_shift_ctrl

Overview:
- Command-driven sequencer for a universal shift register (USR) datapath.
- Accepts one shift or rotate command at a time over a valid/ready interface.
- Parallel-loads the operand, issues the required number of single-bit shift cycles with the correct mode select and serial-in values, then returns the result over a valid/ready response channel.
- Sits between a register-file or ALU front end and the USR core. It provides the only legal way to drive the USR's mode select (s), SINR and SINL.

Parameters:
WIDTH, 4, datapath width in bits; must be ≥2.
CNT_W, 3, width of shift-amount field; amounts 0..2^CNT_W-1.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command; high only in IDLE.
cmd_op  in  3  000 LOAD, 001 SLL, 010 SRL, 011 ROL, 100 ROR, 101 SRA, 110/111 illegal.
cmd_amt  in  CNT_W  shift amount.
cmd_data  in  WIDTH  operand.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer accepts result.
rsp_data  out  WIDTH  result; stable while rsp_valid=1.
rsp_err  out  1  set with rsp_valid for an illegal op.
s  out  2  USR mode select: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
sinr  out  1  serial-in for right shift; becomes new MSB.
sinl  out  1  serial-in for left shift; becomes new LSB.
busy  out  1  high in any state other than IDLE.

Behaviour:
- The USR core is instantiated inside the block; its output Q feeds rsp_data.
- Reset (reset=0, asynchronous) forces the following, regardless of the current state:
  - state=IDLE, Q=0, s=00, sinr=sinl=0;
  - rsp_valid=0, rsp_err=0, busy=0, cmd_ready=0 while reset is held;
  - any command in flight is discarded.
- FSM states: IDLE, LOAD, SHIFT, RESP.
  - IDLE: cmd_ready=1, s=00. On cmd_valid&&cmd_ready, latch op/amt/data into internal registers.
    - Legal op → LOAD.
    - Illegal op → RESP with rsp_err=1; Q is unchanged.
  - LOAD: s=11 for exactly one cycle; Q←latched data.
    - Next state is RESP if op==LOAD or the effective amount is 0; otherwise SHIFT. The remaining-count register is set to the effective amount.
  - SHIFT: one shift per cycle; the count decrements each cycle and the FSM moves to RESP after the edge on which the count reaches 0.
    - SLL: s=01, sinl=0.
    - ROL: s=01, sinl=Q[WIDTH-1].
    - SRL: s=10, sinr=0.
    - ROR: s=10, sinr=Q[0].
    - SRA: s=10, sinr=Q[WIDTH-1].
  - RESP: s=00, rsp_valid=1, rsp_data=Q. Hold all outputs until rsp_ready=1, then go to IDLE; rsp_valid and rsp_err clear.
- Latency: rsp_valid rises N+1 edges after the accepting edge, where N = effective shift count (0 for LOAD). For an illegal op, rsp_valid rises 1 edge after accept.
- No command acceptance while busy; cmd_ready=0 in LOAD, SHIFT and RESP, so at most one command is outstanding.
- Amounts ≥ WIDTH are executed literally:
  - logical shifts produce 0;
  - SRA produces a full sign fill;
  - rotates wrap modulo WIDTH through repeated cycles.
- rsp_ready is ignored outside RESP. cmd_* inputs are ignored outside IDLE.
- Unused serial input (sinl during right shifts, sinr during left shifts) is driven 0.

Optional Feature:
- Macro: USR_CTRL_FASTAMT_EN.
- Defined (WIDTH must be a power of two):
  - rotates use amt mod WIDTH;
  - SLL, SRL and SRA use min(amt, WIDTH).
  - Results are bit-identical to the undefined case; only latency shrinks.
- Undefined: the effective amount equals cmd_amt.

Decomposition:
- Shared package usr_pkg holds:
  - op-code constants (OP_LOAD..OP_SRA);
  - s-mode constants (S_HOLD=00, S_SHL=01, S_SHR=10, S_LOAD=11);
  - FSM state encoding.
- One natural sub-module: usr_core, the WIDTH-parameterised universal shift register driven by s, sinr and sinl. The controller FSM, count register and response logic stay in usr_shift_ctrl.

Test Plan (WIDTH=4):
- Reset: hold reset=0 for 2 cycles mid-SHIFT → next cycle rsp_valid=0, busy=0, Q=0000, s=00; after release, cmd_ready=1.
- SLL data=1011 amt=2 → s sequence 11,01,01; rsp_data=1100 with rsp_valid 3 edges after accept; then ROR data=1001 amt=1 → 1100.
- SRA data=1000 amt=2 → 1110; SRL data=1000 amt=7 → 0000 (7 shift cycles without the macro, 4 with it).
- ROL data=0011 amt=5 → 0110; rsp latency 6 edges without USR_CTRL_FASTAMT_EN, 2 edges with it.
- Backpressure: rsp_ready=0 for 3 cycles in RESP → rsp_data stable, cmd_ready=0, and cmd_valid with a new command is not accepted; accepted one cycle after the response handshake.
- Illegal op=110 after previous result 1100 → rsp_err=1, rsp_data=1100 one edge after accept; no s=11 cycle issued. LOAD data=0101 amt=3 → rsp_data=0101 after 1 edge, no shift cycles.
